// File: rtl/uart_port.sv
// uart_port: memory-mapped UART with BAUD/CTRL/STAT/DATA registers,
// 8N1 transmitter and receiver, and a one-cycle interrupt pulse.
// Build option: define UART_RX_EN to include the receiver. Without it only
// the transmitter exists and i_rxPin is ignored.

module uart_port (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [1:0]  i_memAddr,
    input  logic [15:0] i_memDataIn,
    input  logic        i_memWrEn,
    output logic [15:0] o_memDataOut,
    input  logic        i_smIsBooted,
    input  logic        i_rxPin,
    output logic        o_txPin,
    output logic        o_intUART
);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;

    logic [15:0] r_baud;
    logic        r_txEn;
    logic        r_txIe;
    logic        r_int;

    txState_t    r_txState;
    txState_t    w_txNext;
    logic [15:0] r_txCnt;
    logic [2:0]  r_txBit;
    logic [7:0]  r_txShift;

    logic        w_wrBaud;
    logic        w_wrCtrl;
    logic        w_wrData;
    logic        w_txBusy;
    logic        w_txBitEnd;
    logic        w_txStart;
    logic        w_txDone;

    logic        w_rxIe;
    logic        w_rxEn;
    logic        w_rxValid;
    logic        w_rxOvr;
    logic        w_frmErr;
    logic [7:0]  w_rxByte;
    logic        w_rxBusy;
    logic        w_rxInt;

    assign w_wrBaud   = i_memWrEn && (i_memAddr == 2'd0);
    assign w_wrCtrl   = i_memWrEn && (i_memAddr == 2'd1);
    assign w_wrData   = i_memWrEn && (i_memAddr == 2'd3);

    assign w_txBusy   = (r_txState != TX_IDLE);
    assign w_txBitEnd = (r_txCnt == r_baud);
    assign w_txStart  = w_wrData && r_txEn && !w_txBusy && i_smIsBooted;
    assign w_txDone   = (r_txState == TX_STOP) && w_txBitEnd && i_smIsBooted;

    // BAUD may only change while both directions are idle, so a bit period never shifts mid-frame.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_baud <= 16'd0;
        end else if (w_wrBaud && !w_txBusy && !w_rxBusy) begin
            r_baud <= i_memDataIn;
        end
    end

    // TX half of CTRL; TXIE stays usable in TX-only builds so TX-done can still interrupt.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_txEn <= 1'b0;
            r_txIe <= 1'b0;
        end else if (w_wrCtrl) begin
            r_txEn <= i_memDataIn[0];
            r_txIe <= i_memDataIn[2];
        end
    end

    // TX state register.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_txState <= TX_IDLE;
        end else begin
            r_txState <= w_txNext;
        end
    end

    // TX next-state: each bit lasts BAUD+1 cycles; an unbooted system parks the FSM in IDLE.
    always_comb begin
        w_txNext = r_txState;
        if (!i_smIsBooted) begin
            w_txNext = TX_IDLE;
        end else begin
            case (r_txState)
                TX_IDLE:  if (w_txStart) w_txNext = TX_START;
                TX_START: if (w_txBitEnd) w_txNext = TX_DATA;
                TX_DATA:  if (w_txBitEnd && (r_txBit == 3'd7)) w_txNext = TX_STOP;
                TX_STOP:  if (w_txBitEnd) w_txNext = TX_IDLE;
                default:  w_txNext = TX_IDLE;
            endcase
        end
    end

    // TX datapath: bit-period counter, data bit index and LSB-first shifter.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_txCnt   <= 16'd0;
            r_txBit   <= 3'd0;
            r_txShift <= 8'd0;
        end else if (w_txStart) begin
            r_txCnt   <= 16'd0;
            r_txBit   <= 3'd0;
            r_txShift <= i_memDataIn[7:0];
        end else if (r_txState != TX_IDLE) begin
            if (w_txBitEnd) begin
                r_txCnt <= 16'd0;
                if (r_txState == TX_DATA) begin
                    r_txShift <= {1'b0, r_txShift[7:1]};
                    r_txBit   <= r_txBit + 3'd1;
                end
            end else begin
                r_txCnt <= r_txCnt + 16'd1;
            end
        end
    end

    // Serial line level follows the TX state; anything but START/DATA idles high.
    always_comb begin
        o_txPin = 1'b1;
        if (i_smIsBooted) begin
            case (r_txState)
                TX_START: o_txPin = 1'b0;
                TX_DATA:  o_txPin = r_txShift[0];
                default:  o_txPin = 1'b1;
            endcase
        end
    end

`ifdef UART_RX_EN
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

    logic        r_rxIe;
    logic        r_rxEn;
    logic        r_rxValid;
    logic        r_rxOvr;
    logic        r_frmErr;
    logic [7:0]  r_rxByte;
    logic        r_rxSync1;
    logic        r_rxSync2;
    rxState_t    r_rxState;
    rxState_t    w_rxNext;
    logic [15:0] r_rxCnt;
    logic [2:0]  r_rxBit;
    logic [7:0]  r_rxShift;

    logic        w_wrStat;
    logic        w_rxActive;
    logic [15:0] w_rxHalf;
    logic        w_rxStartSample;
    logic        w_rxBitEnd;
    logic        w_rxDone;
    logic        w_rxStopOk;
    logic        w_rxFrameErr;

    assign w_wrStat        = i_memWrEn && (i_memAddr == 2'd2);
    assign w_rxActive      = r_rxEn && i_smIsBooted;
    assign w_rxHalf        = {1'b0, r_baud[15:1]};
    assign w_rxStartSample = (r_rxState == RX_START) && (r_rxCnt >= w_rxHalf);
    assign w_rxBitEnd      = (r_rxCnt == r_baud);
    assign w_rxDone        = (r_rxState == RX_STOP) && w_rxBitEnd && w_rxActive;
    assign w_rxStopOk      = w_rxDone && r_rxSync2;
    assign w_rxFrameErr    = w_rxDone && !r_rxSync2;

    assign w_rxIe    = r_rxIe;
    assign w_rxEn    = r_rxEn;
    assign w_rxValid = r_rxValid;
    assign w_rxOvr   = r_rxOvr;
    assign w_frmErr  = r_frmErr;
    assign w_rxByte  = r_rxByte;
    assign w_rxBusy  = (r_rxState != RX_IDLE);
    assign w_rxInt   = w_rxStopOk && !r_rxValid && r_rxIe;

    // RX half of CTRL.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_rxEn <= 1'b0;
            r_rxIe <= 1'b0;
        end else if (w_wrCtrl) begin
            r_rxEn <= i_memDataIn[1];
            r_rxIe <= i_memDataIn[3];
        end
    end

    // Two-flop synchroniser for the asynchronous RX pin; resets to the idle-high level.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_rxSync1 <= 1'b1;
            r_rxSync2 <= 1'b1;
        end else begin
            r_rxSync1 <= i_rxPin;
            r_rxSync2 <= r_rxSync1;
        end
    end

    // RX state register.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_rxState <= RX_IDLE;
        end else begin
            r_rxState <= w_rxNext;
        end
    end

    // RX next-state: a start bit still high at its midpoint is treated as a glitch.
    always_comb begin
        w_rxNext = r_rxState;
        if (!w_rxActive) begin
            w_rxNext = RX_IDLE;
        end else begin
            case (r_rxState)
                RX_IDLE:  if (!r_rxSync2) w_rxNext = RX_START;
                RX_START: if (w_rxStartSample) w_rxNext = r_rxSync2 ? RX_IDLE : RX_DATA;
                RX_DATA:  if (w_rxBitEnd && (r_rxBit == 3'd7)) w_rxNext = RX_STOP;
                RX_STOP:  if (w_rxBitEnd) w_rxNext = RX_IDLE;
                default:  w_rxNext = RX_IDLE;
            endcase
        end
    end

    // RX datapath: the counter enters START at 1 so the start midpoint lands BAUD>>1 cycles in.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_rxCnt   <= 16'd0;
            r_rxBit   <= 3'd0;
            r_rxShift <= 8'd0;
        end else begin
            case (r_rxState)
                RX_IDLE: begin
                    r_rxCnt <= 16'd1;
                    r_rxBit <= 3'd0;
                end
                RX_START: begin
                    r_rxCnt <= w_rxStartSample ? 16'd0 : r_rxCnt + 16'd1;
                end
                RX_DATA: begin
                    if (w_rxBitEnd) begin
                        r_rxCnt   <= 16'd0;
                        r_rxShift <= {r_rxSync2, r_rxShift[7:1]};
                        r_rxBit   <= r_rxBit + 3'd1;
                    end else begin
                        r_rxCnt <= r_rxCnt + 16'd1;
                    end
                end
                default: begin
                    r_rxCnt <= w_rxBitEnd ? 16'd0 : r_rxCnt + 16'd1;
                end
            endcase
        end
    end

    // Status flags: hardware set beats a same-cycle write-1-to-clear; a held byte is never overwritten.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_rxValid <= 1'b0;
            r_rxOvr   <= 1'b0;
            r_frmErr  <= 1'b0;
            r_rxByte  <= 8'd0;
        end else begin
            if (w_rxStopOk && !r_rxValid) begin
                r_rxValid <= 1'b1;
                r_rxByte  <= r_rxShift;
            end else if (w_wrStat && i_memDataIn[1]) begin
                r_rxValid <= 1'b0;
            end
            if (w_rxStopOk && r_rxValid) begin
                r_rxOvr <= 1'b1;
            end else if (w_wrStat && i_memDataIn[2]) begin
                r_rxOvr <= 1'b0;
            end
            if (w_rxFrameErr) begin
                r_frmErr <= 1'b1;
            end else if (w_wrStat && i_memDataIn[3]) begin
                r_frmErr <= 1'b0;
            end
        end
    end
`else
    logic w_unusedRxPin;

    assign w_unusedRxPin = i_rxPin;
    assign w_rxIe        = 1'b0;
    assign w_rxEn        = 1'b0;
    assign w_rxValid     = 1'b0;
    assign w_rxOvr       = 1'b0;
    assign w_frmErr      = 1'b0;
    assign w_rxByte      = 8'd0;
    assign w_rxBusy      = 1'b0;
    assign w_rxInt       = 1'b0;
`endif

    // One registered pulse even when TX-done and RX-done coincide.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_int <= 1'b0;
        end else begin
            r_int <= (w_txDone && r_txIe) || w_rxInt;
        end
    end

    assign o_intUART = r_int;

    // Combinational register read mux; unused bits read 0.
    always_comb begin
        o_memDataOut = 16'd0;
        case (i_memAddr)
            2'd0: o_memDataOut = r_baud;
            2'd1: o_memDataOut = {12'd0, w_rxIe, r_txIe, w_rxEn, r_txEn};
            2'd2: o_memDataOut = {12'd0, w_frmErr, w_rxOvr, w_rxValid, w_txBusy};
            default: o_memDataOut = {8'd0, w_rxByte};
        endcase
    end

endmodule

// File: tb/tb_uart_port.sv
// Testbench for uart_port: register reads go through a scoreboard queue,
// TX frames are checked bit-by-bit by a line monitor, interrupts are counted.
// Honours UART_RX_EN the same way as the design.

module tb_uart_port;

    logic        clock;
    logic        rstn;
    logic [1:0]  memAddr;
    logic [15:0] memDataIn;
    logic        memWrEn;
    logic [15:0] memDataOut;
    logic        smIsBooted;
    logic        rxPin;
    logic        txPin;
    logic        intUART;

    int          tbChecks;
    int          tbErrors;
    int          tbIntCount;
    int          tbFramesDone;
    int          tbP;
    logic        tbTxIe;
    logic        tbReadStrobe;

    logic [15:0] expQ[$];
    string       nameQ[$];
    logic [7:0]  txExpQ[$];

    uart_port dut (
        .i_clk        (clock),
        .i_rstn       (rstn),
        .i_memAddr    (memAddr),
        .i_memDataIn  (memDataIn),
        .i_memWrEn    (memWrEn),
        .o_memDataOut (memDataOut),
        .i_smIsBooted (smIsBooted),
        .i_rxPin      (rxPin),
        .o_txPin      (txPin),
        .o_intUART    (intUART)
    );

    // 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point used by every checker.
    task automatic checkValue(input string name, input logic [15:0] act, input logic [15:0] exp);
        tbChecks++;
        if (act !== exp) begin
            tbErrors++;
            $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    // Register write, sampled by the DUT at the second rising edge.
    task automatic applyStimulus(input logic [1:0] addr, input logic [15:0] data);
        @(posedge clock);
        #1;
        memAddr   = addr;
        memDataIn = data;
        memWrEn   = 1'b1;
        @(posedge clock);
        #1;
        memWrEn   = 1'b0;
    endtask

    // Register read: expected value goes to the scoreboard, the monitor compares.
    task automatic checkOutput(input logic [1:0] addr, input logic [15:0] exp, input string name);
        @(posedge clock);
        #1;
        memAddr = addr;
        expQ.push_back(exp);
        nameQ.push_back(name);
        tbReadStrobe = 1'b1;
        @(posedge clock);
        #1;
        tbReadStrobe = 1'b0;
    endtask

    // Drive one 8N1 frame on rxPin at the current bit period. A bad stop bit is
    // held only two cycles so the low line does not look like a new start bit.
    task automatic sendRxByte(input logic [7:0] data, input logic stopBit);
        logic [9:0] frame;
        int hold;
        frame = {stopBit, data, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(posedge clock);
            #1;
            rxPin = frame[k];
            hold = (k == 9 && !stopBit) ? 2 : tbP;
            repeat (hold - 1) @(posedge clock);
        end
        @(posedge clock);
        #1;
        rxPin = 1'b1;
        repeat (6) @(posedge clock);
    endtask

    // Bounded wait for the TX monitor to finish a given number of frames.
    task automatic waitFrames(input int target);
        for (int i = 0; i < 600; i++) begin
            if (tbFramesDone >= target) break;
            @(posedge clock);
        end
        checkValue("txFrameCount", 16'(tbFramesDone), 16'(target));
    endtask

    // Scoreboard monitor: pops one expectation per read strobe.
    initial begin : readMonitor
        logic [15:0] expVal;
        string       expName;
        forever begin
            @(negedge clock);
            if (tbReadStrobe) begin
                if (expQ.size() == 0) begin
                    checkValue("readUnexpected", memDataOut, 16'hxxxx);
                end else begin
                    expVal  = expQ.pop_front();
                    expName = nameQ.pop_front();
                    checkValue(expName, memDataOut, expVal);
                end
            end
        end
    end

    // Interrupt pulse counter.
    always @(negedge clock) begin
        if (intUART === 1'b1) tbIntCount++;
    end

    // TX line monitor: every cycle of a frame must match the expected bit; a reset aborts the frame.
    initial begin : txMonitor
        logic [7:0] expByte;
        logic [9:0] frameBits;
        logic [9:0] midBits;
        logic       timingOk;
        logic       aborted;
        int         p;
        forever begin
            @(negedge clock);
            if (rstn === 1'b1 && txPin === 1'b0) begin
                if (txExpQ.size() == 0) begin
                    $display("[TB] FAIL txUnexpected: frame started with nothing queued");
                    tbChecks++;
                    tbErrors++;
                    expByte = 8'h00;
                end else begin
                    expByte = txExpQ.pop_front();
                end
                frameBits = {1'b1, expByte, 1'b0};
                midBits   = 10'd0;
                timingOk  = 1'b1;
                aborted   = 1'b0;
                p         = tbP;
                for (int c = 0; c < 10 * p; c++) begin
                    if (c > 0) @(negedge clock);
                    if (rstn !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (txPin !== frameBits[c / p]) timingOk = 1'b0;
                    if ((c % p) == (p / 2)) midBits[c / p] = txPin;
                end
                if (!aborted) begin
                    checkValue("txFrameBits", {6'd0, midBits}, {6'd0, frameBits});
                    checkValue("txBitTiming", {15'd0, timingOk}, 16'd1);
                    @(negedge clock);
                    checkValue("txDoneIdle", {15'd0, txPin}, 16'd1);
                    checkValue("txDoneInt", {15'd0, intUART}, {15'd0, tbTxIe});
                    tbFramesDone++;
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        tbChecks     = 0;
        tbErrors     = 0;
        tbIntCount   = 0;
        tbFramesDone = 0;
        tbP          = 4;
        tbTxIe       = 1'b0;
        tbReadStrobe = 1'b0;
        rstn         = 1'b0;
        memAddr      = 2'd0;
        memDataIn    = 16'd0;
        memWrEn      = 1'b0;
        smIsBooted   = 1'b1;
        rxPin        = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        rstn = 1'b1;

        $display("[TB] reset values");
        @(negedge clock);
        checkValue("resetTxPin", {15'd0, txPin}, 16'd1);
        checkValue("resetInt", {15'd0, intUART}, 16'd0);
        checkOutput(2'd0, 16'h0000, "resetBaud");
        checkOutput(2'd1, 16'h0000, "resetCtrl");
        checkOutput(2'd2, 16'h0000, "resetStat");
        checkOutput(2'd3, 16'h0000, "resetData");

        $display("[TB] TX frame 0xA5 at P=4");
        applyStimulus(2'd0, 16'd3);
        applyStimulus(2'd1, 16'h0005);
        checkOutput(2'd0, 16'd3, "baudWrite");
        checkOutput(2'd1, 16'h0005, "ctrlWrite");
        tbTxIe = 1'b1;
        txExpQ.push_back(8'hA5);
        applyStimulus(2'd3, 16'h00A5);
        checkOutput(2'd2, 16'h0001, "txBusyHigh");
        applyStimulus(2'd3, 16'h003C);
        applyStimulus(2'd0, 16'd7);
        waitFrames(1);
        checkOutput(2'd0, 16'd3, "baudIgnoredWhileBusy");
        checkOutput(2'd2, 16'h0000, "txBusyLow");
        checkValue("txIntCount1", 16'(tbIntCount), 16'd1);

        $display("[TB] back-to-back TX frame 0x81");
        txExpQ.push_back(8'h81);
        applyStimulus(2'd3, 16'h0081);
        waitFrames(2);
        checkValue("txIntCount2", 16'(tbIntCount), 16'd2);

`ifdef UART_RX_EN
        $display("[TB] RX byte 0x5A");
        tbTxIe = 1'b0;
        applyStimulus(2'd1, 16'h000A);
        sendRxByte(8'h5A, 1'b1);
        checkOutput(2'd2, 16'h0002, "rxValidSet");
        checkOutput(2'd3, 16'h005A, "rxData");
        checkValue("rxIntCount", 16'(tbIntCount), 16'd3);

        $display("[TB] RX overrun");
        sendRxByte(8'hC3, 1'b1);
        checkOutput(2'd2, 16'h0006, "rxOverrun");
        checkOutput(2'd3, 16'h005A, "rxDataKept");
        checkValue("rxOvrNoInt", 16'(tbIntCount), 16'd3);
        applyStimulus(2'd2, 16'h0006);
        checkOutput(2'd2, 16'h0000, "statW1C");

        $display("[TB] RX framing error");
        sendRxByte(8'h11, 1'b0);
        checkOutput(2'd2, 16'h0008, "frameError");
        checkOutput(2'd3, 16'h005A, "frameErrDataKept");
        checkValue("frmErrNoInt", 16'(tbIntCount), 16'd3);
        applyStimulus(2'd2, 16'h0008);
        checkOutput(2'd2, 16'h0000, "frmErrClear");

        $display("[TB] RX start glitch");
        @(posedge clock);
        #1;
        rxPin = 1'b0;
        @(posedge clock);
        #1;
        rxPin = 1'b1;
        repeat (20) @(posedge clock);
        checkOutput(2'd2, 16'h0000, "glitchNoFlags");
        applyStimulus(2'd0, 16'd5);
        checkOutput(2'd0, 16'd5, "glitchRxIdle");
        applyStimulus(2'd0, 16'd3);
        checkValue("glitchNoInt", 16'(tbIntCount), 16'd3);
`else
        $display("[TB] TX-only build: RX bits inert");
        applyStimulus(2'd1, 16'h000F);
        checkOutput(2'd1, 16'h0005, "ctrlRxBitsZero");
        applyStimulus(2'd2, 16'h000E);
        checkOutput(2'd2, 16'h0000, "statRxBitsZero");
        sendRxByte(8'h5A, 1'b1);
        checkOutput(2'd3, 16'h0000, "dataReadsZero");
        checkOutput(2'd2, 16'h0000, "statStillZero");
        checkValue("noRxInt", 16'(tbIntCount), 16'd2);
`endif

        $display("[TB] reset mid-frame");
        tbTxIe = 1'b0;
        applyStimulus(2'd1, 16'h0001);
        txExpQ.push_back(8'h55);
        applyStimulus(2'd3, 16'h0055);
        repeat (10) @(posedge clock);
        #1;
        rstn = 1'b0;
        @(posedge clock);
        #1;
        rstn = 1'b1;
        @(negedge clock);
        checkValue("midResetTxPin", {15'd0, txPin}, 16'd1);
        checkOutput(2'd0, 16'h0000, "midResetBaud");
        checkOutput(2'd1, 16'h0000, "midResetCtrl");
        checkOutput(2'd2, 16'h0000, "midResetStat");

        for (int i = 0; i < 10; i++) begin
            if (expQ.size() == 0) break;
            @(posedge clock);
        end
        checkValue("scoreboardDrained", 16'(expQ.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", tbChecks, tbErrors);
        $finish;
    end

endmodule
